uart_tx_scheduler: RTL and testbench

//  Shares one UART transmitter between NUM_REQ byte sources, using round-robin arbitration with frame locking.
//  - Sits between the on-chip producers (counter/status reporters, loopback echo) and the single uart_tx serializer.
//  - A granted source keeps the line until it sends req_last, hits MAX_BURST bytes, or stalls past STALL_TIMEOUT.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/rr_pick.sv | 36 +++
 rtl/uart_tx_scheduler.sv | 121 ++++++++++++
 tb/tb_uart_tx_scheduler.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ============================================================================
// Module  : uart_pkg
// Brief   : Shared UART constants and the TX scheduler state encoding.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int DATA_W      = 8;
    localparam int SCHED_CNT_W = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } sched_state_e;

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
// Module  : rr_pick
// Brief   : Rotate-priority encoder: first set request at or above ptr, wrapping.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic                       found,
    output logic [$clog2(NUM_REQ)-1:0] idx
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0] cand;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = IDX_W'((int'(ptr) + i) % NUM_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
// ============================================================================
// Module  : uart_tx_scheduler
// Brief   : Round-robin, frame-locked sharing of one uart_tx among NUM_REQ sources.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_scheduler #(
    parameter int NUM_REQ       = 4,
    parameter int DATA_W        = uart_pkg::DATA_W,
    parameter int MAX_BURST     = 4,
    parameter int STALL_TIMEOUT = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       tx_valid,
    output logic [DATA_W-1:0]          tx_data,
    input  logic                       tx_ready,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       stall_err
);

    import uart_pkg::*;

    localparam int               IDX_W     = $clog2(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);
    localparam logic [SCHED_CNT_W-1:0] BURST_END = SCHED_CNT_W'(MAX_BURST - 1);
    localparam logic [SCHED_CNT_W-1:0] STALL_END = SCHED_CNT_W'(STALL_TIMEOUT - 1);
    localparam logic [SCHED_CNT_W-1:0] STALL_SAT = SCHED_CNT_W'(STALL_TIMEOUT);

    sched_state_e           state;
    logic [IDX_W-1:0]       rr_ptr;
    logic [IDX_W-1:0]       next_ptr;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_found;
    logic [SCHED_CNT_W-1:0] burst_cnt;
    logic [SCHED_CNT_W-1:0] stall_cnt;
    logic                   owner_valid;
    logic                   owner_last;
    logic                   beat;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign busy     = (state == XFER);
    assign next_ptr = (grant_id == LAST_IDX) ? '0 : grant_id + 1'b1;

    // Output mux is gated by busy so nothing reaches uart_tx while idle or in reset.
    always_comb begin
        owner_valid = req_valid[grant_id];
        owner_last  = req_last[grant_id];
        tx_valid    = busy & owner_valid;
        tx_data     = busy ? req_data[int'(grant_id)*DATA_W +: DATA_W] : '0;
        req_ready   = '0;
        if (busy) begin
            req_ready[grant_id] = tx_ready;
        end
        beat        = tx_valid & tx_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant_id  <= '0;
            burst_cnt <= '0;
            stall_cnt <= '0;
            stall_err <= 1'b0;
        end else begin
            stall_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant_id  <= pick_idx;
                        burst_cnt <= '0;
                        stall_cnt <= '0;
                        state     <= XFER;
                    end
                end
                XFER: begin
                    if (beat) begin
                        stall_cnt <= '0;
                        if (owner_last || (burst_cnt == BURST_END)) begin
                            burst_cnt <= '0;
                            rr_ptr    <= next_ptr;
                            state     <= IDLE;
                        end else begin
                            burst_cnt <= burst_cnt + 1'b1;
                        end
                    end else if (!owner_valid) begin
                        // Backpressure (valid high, tx_ready low) holds stall_cnt.
                        if (stall_cnt == STALL_END) begin
                            stall_cnt <= STALL_SAT;
                            stall_err <= 1'b1;
                            burst_cnt <= '0;
                            rr_ptr    <= next_ptr;
                            state     <= IDLE;
                        end else begin
                            stall_cnt <= stall_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
// ============================================================================
// Module  : tb_uart_tx_scheduler
// Brief   : Directed self-checking bench for uart_tx_scheduler (4 sources).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_scheduler;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic [1:0]  grant_id;
    logic        busy;
    logic        stall_err;

    int n_checks = 0;
    int n_fail   = 0;

    uart_tx_scheduler #(
        .NUM_REQ       (4),
        .DATA_W        (8),
        .MAX_BURST     (4),
        .STALL_TIMEOUT (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .grant_id  (grant_id),
        .busy      (busy),
        .stall_err (stall_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 2 time units after the rising edge, outputs are read 1 unit later.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        tx_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst_n  = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 4'hF; req_data = 32'hDEADBEEF; req_last = 4'hF; tx_ready = 1'b1;
        #1;
        n_checks++;
        if ({busy, tx_valid, tx_data, req_ready, grant_id, stall_err} !== 17'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b tx_valid=%b tx_data=%h req_ready=%b grant=%0d stall_err=%b, want all 0",
                     busy, tx_valid, tx_data, req_ready, grant_id, stall_err);
        end
        apply_reset();
        #1;
        n_checks++;
        if ({busy, tx_valid, req_ready, stall_err} !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_release_idle: got busy=%b tx_valid=%b req_ready=%b stall_err=%b, want 0",
                     busy, tx_valid, req_ready, stall_err);
        end
    endtask

    task automatic test_single_frame();
        logic [7:0] bytes [3] = '{8'h41, 8'h42, 8'h43};
        apply_reset();
        req_valid = 4'b0001;
        req_data[7:0] = bytes[0];
        #1;
        n_checks++;
        if (tx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_latency: tx_valid=%b before arbitration edge, want 0", tx_valid);
        end
        tick();
        for (int k = 0; k < 3; k++) begin
            req_data[7:0] = bytes[k];
            req_last[0]   = (k == 2);
            #1;
            n_checks++;
            if ({tx_valid, tx_data, req_ready, grant_id} !== {1'b1, bytes[k], 4'b0001, 2'd0}) begin
                n_fail++;
                $display("FAIL single_beat%0d: tx_valid=%b tx_data=%h req_ready=%b grant=%0d, want 1 %h 0001 0",
                         k, tx_valid, tx_data, req_ready, grant_id, bytes[k]);
            end
            tick();
        end
        // Owner 0 and source 1 both request: advanced pointer must favour 1.
        req_valid = 4'b0011;
        req_last  = 4'b0011;
        req_data[15:8] = 8'h51;
        #1;
        n_checks++;
        if ({busy, tx_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL single_release: busy=%b tx_valid=%b after last beat, want 0 0", busy, tx_valid);
        end
        tick();
        #1;
        n_checks++;
        if ({grant_id, tx_data} !== {2'd1, 8'h51}) begin
            n_fail++;
            $display("FAIL single_next_owner: grant=%0d tx_data=%h, want 1 51", grant_id, tx_data);
        end
        tick();
        req_valid = '0;
    endtask

    task automatic test_round_robin();
        int order [5] = '{0, 1, 2, 3, 0};
        apply_reset();
        req_valid = 4'hF;
        req_last  = 4'hF;
        req_data  = 32'h13121110;
        for (int g = 0; g < 5; g++) begin
            tick();
            #1;
            n_checks++;
            if ({busy, grant_id, req_ready, tx_data} !== {1'b1, 2'(order[g]), 4'(1 << order[g]), 8'(8'h10 + order[g])}) begin
                n_fail++;
                $display("FAIL rr_grant%0d: busy=%b grant=%0d req_ready=%b tx_data=%h, want owner %0d",
                         g, busy, grant_id, req_ready, tx_data, order[g]);
            end
            tick();
            #1;
            n_checks++;
            if ({busy, req_ready, tx_valid} !== 6'd0) begin
                n_fail++;
                $display("FAIL rr_bubble%0d: busy=%b req_ready=%b tx_valid=%b, want idle bubble",
                         g, busy, req_ready, tx_valid);
            end
        end
        req_valid = '0;
    endtask

    task automatic test_max_burst();
        apply_reset();
        req_valid = 4'b1100;
        req_last  = 4'b1000;
        req_data[31:24] = 8'h33;
        tick();
        for (int k = 0; k < 6; k++) begin
            req_data[23:16] = 8'hA0 + 8'(k);
            req_last[2]     = (k == 5);
            #1;
            n_checks++;
            if ({grant_id, tx_data, req_ready} !== {2'd2, 8'hA0 + 8'(k), 4'b0100}) begin
                n_fail++;
                $display("FAIL burst_beat%0d: grant=%0d tx_data=%h req_ready=%b, want 2 %h 0100",
                         k, grant_id, tx_data, req_ready, 8'hA0 + 8'(k));
            end
            tick();
            if (k == 3) begin
                #1;
                n_checks++;
                if (busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL burst_release: busy=%b after 4th beat, want 0", busy);
                end
                tick();
                #1;
                n_checks++;
                if ({grant_id, tx_data, req_ready} !== {2'd3, 8'h33, 4'b1000}) begin
                    n_fail++;
                    $display("FAIL burst_rotate: grant=%0d tx_data=%h req_ready=%b, want 3 33 1000",
                             grant_id, tx_data, req_ready);
                end
                tick();
                req_valid[3] = 1'b0;
                tick();
            end
        end
        #1;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL burst_final_release: busy=%b, want 0", busy);
        end
        req_valid = '0;
    endtask

    task automatic test_backpressure();
        apply_reset();
        req_valid = 4'b0010;
        req_last  = 4'b0010;
        req_data[15:8] = 8'h5A;
        tx_ready  = 1'b0;
        tick();
        for (int c = 0; c < 40; c++) begin
            #1;
            n_checks++;
            if ({busy, tx_valid, tx_data, req_ready, stall_err} !== {1'b1, 1'b1, 8'h5A, 4'b0000, 1'b0}) begin
                n_fail++;
                $display("FAIL bp_hold%0d: busy=%b tx_valid=%b tx_data=%h req_ready=%b stall_err=%b",
                         c, busy, tx_valid, tx_data, req_ready, stall_err);
            end
            tick();
        end
        tx_ready = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL bp_accept: req_ready=%b, want 0010", req_ready);
        end
        tick();
        #1;
        n_checks++;
        if ({busy, stall_err} !== 2'b00) begin
            n_fail++;
            $display("FAIL bp_done: busy=%b stall_err=%b, want 0 0", busy, stall_err);
        end
        req_valid = '0;
    endtask

    task automatic test_stall();
        apply_reset();
        req_valid = 4'b0011;
        req_last  = 4'b0010;
        req_data[15:0] = 16'h7161;
        tick();
        #1;
        n_checks++;
        if ({grant_id, tx_data, req_ready} !== {2'd0, 8'h61, 4'b0001}) begin
            n_fail++;
            $display("FAIL stall_first_byte: grant=%0d tx_data=%h req_ready=%b, want 0 61 0001",
                     grant_id, tx_data, req_ready);
        end
        tick();
        req_valid[0] = 1'b0;
        for (int c = 0; c < 16; c++) begin
            #1;
            n_checks++;
            if ({busy, tx_valid, stall_err} !== 3'b100) begin
                n_fail++;
                $display("FAIL stall_wait%0d: busy=%b tx_valid=%b stall_err=%b, want 1 0 0",
                         c, busy, tx_valid, stall_err);
            end
            tick();
        end
        #1;
        n_checks++;
        if ({busy, stall_err} !== 2'b01) begin
            n_fail++;
            $display("FAIL stall_revoke: busy=%b stall_err=%b, want 0 1", busy, stall_err);
        end
        tick();
        #1;
        n_checks++;
        if ({busy, grant_id, tx_data, stall_err} !== {1'b1, 2'd1, 8'h71, 1'b0}) begin
            n_fail++;
            $display("FAIL stall_rotate: busy=%b grant=%0d tx_data=%h stall_err=%b, want 1 1 71 0",
                     busy, grant_id, tx_data, stall_err);
        end
        tick();
        req_valid = '0;
    endtask

    task automatic test_reset_mid_xfer();
        apply_reset();
        req_valid = 4'b0010;
        req_last  = 4'b0010;
        tick();
        tick();
        req_valid = 4'b0100;
        req_last  = 4'b0000;
        req_data[23:16] = 8'h99;
        tick();
        #1;
        n_checks++;
        if ({grant_id, tx_valid, tx_data} !== {2'd2, 1'b1, 8'h99}) begin
            n_fail++;
            $display("FAIL rstmid_setup: grant=%0d tx_valid=%b tx_data=%h, want 2 1 99",
                     grant_id, tx_valid, tx_data);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, tx_valid, tx_data, req_ready, grant_id, stall_err} !== 17'd0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: busy=%b tx_valid=%b tx_data=%h req_ready=%b grant=%0d stall_err=%b, want 0",
                     busy, tx_valid, tx_data, req_ready, grant_id, stall_err);
        end
        req_valid = 4'b0101;
        tick();
        rst_n = 1'b1;
        tick();
        #1;
        n_checks++;
        if ({busy, grant_id} !== {1'b1, 2'd0}) begin
            n_fail++;
            $display("FAIL rstmid_regrant: busy=%b grant=%0d, want 1 0", busy, grant_id);
        end
        req_valid = '0;
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_round_robin();
        test_max_burst();
        test_backpressure();
        test_stall();
        test_reset_mid_xfer();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
